// File: rtl/ahb_bridge_pkg.sv
// Shared AHB-Lite constants and sink master
// state encoding for the AHB2AHB bridge.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [31:0] ERR_PATTERN_DEF = 32'hDEAD_BEEF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_PIPE = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_ADDR = ST_ADDR,
    S_PIPE = ST_PIPE,
    S_DATA = ST_DATA,
    S_ERR2 = ST_ERR2
  } sm_state_t;

endpackage

// File: rtl/ahb_sink_master.sv
// AHB-Lite master at the sink end of the bridge:
// turns the controller request stream into NONSEQ singles.
module ahb_sink_master
  import ahb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [2:0] HSIZE_VAL = HSIZE_WORD,
  parameter logic [DATA_WIDTH-1:0] ERR_PATTERN =
    ERR_PATTERN_DEF
) (
  input  logic                  i_clk_sink,
  input  logic                  i_rstn_sink,
  input  logic                  i_valid,
  input  logic                  i_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_ready,
  input  logic                  i_hold,
  output logic                  o_busy,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_haddr,
  output logic [1:0]            o_htrans,
  output logic                  o_hwrite,
  output logic [2:0]            o_hsize,
  output logic [2:0]            o_hburst,
  output logic [DATA_WIDTH-1:0] o_hwdata,
  input  logic [DATA_WIDTH-1:0] i_hrdata,
  input  logic                  i_hready,
  input  logic                  i_hresp
);

  sm_state_t state_q;
  sm_state_t state_d;

  logic [DATA_WIDTH-1:0] wdata_q;
  logic dp_wr_q;
  logic b_held_q;
  logic err_rsp;
  logic rdy_st;
  logic acc;
  logic addr_done;
  logic data_done;
  logic data_err;
  logic enter_err;
  logic reissue;

  assign err_rsp  = (i_hresp == HRESP_ERROR);
  assign o_busy   = (state_q != S_IDLE);
  assign o_hsize  = HSIZE_VAL;
  assign o_hburst = HBURST_SINGLE;

  always_comb begin
    rdy_st = 1'b0;
    unique case (state_q)
      S_IDLE:         rdy_st = 1'b1;
      S_ADDR, S_PIPE: rdy_st = i_hready && !err_rsp;
      S_DATA:         rdy_st = !err_rsp;
      default:        rdy_st = 1'b0;
    endcase
  end

  assign o_ready = i_rstn_sink && !i_hold && rdy_st;
  assign acc     = i_valid && o_ready;

  always_ff @(posedge i_clk_sink) begin
    if (!i_rstn_sink) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    addr_done = 1'b0;
    data_done = 1'b0;
    data_err  = 1'b0;
    enter_err = 1'b0;
    reissue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (i_hready) begin
          addr_done = 1'b1;
          state_d   = acc ? S_PIPE : S_DATA;
        end
      end
      S_PIPE: begin
        if (i_hready) begin
          addr_done = 1'b1;
          data_done = 1'b1;
          data_err  = err_rsp;
          state_d   = acc ? S_PIPE : S_DATA;
        end else if (err_rsp) begin
          enter_err = 1'b1;
          state_d   = S_ERR2;
        end
      end
      S_DATA: begin
        if (i_hready) begin
          data_done = 1'b1;
          data_err  = err_rsp;
          state_d   = acc ? S_ADDR : S_IDLE;
        end else if (err_rsp) begin
          enter_err = 1'b1;
          state_d   = S_ERR2;
        end else if (acc) begin
          state_d = S_PIPE;
        end
      end
      S_ERR2: begin
        if (i_hready) begin
          data_done = 1'b1;
          data_err  = 1'b1;
          reissue   = b_held_q;
          state_d   = b_held_q ? S_ADDR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The cancelled pipelined address stays in o_haddr
  // and is replayed as NONSEQ once ERR2 completes.
  always_ff @(posedge i_clk_sink) begin
    if (!i_rstn_sink) begin
      o_haddr  <= '0;
      o_htrans <= HTRANS_IDLE;
      o_hwrite <= 1'b0;
      o_hwdata <= '0;
      wdata_q  <= '0;
      dp_wr_q  <= 1'b0;
      b_held_q <= 1'b0;
    end else begin
      if (acc) begin
        o_haddr  <= i_addr;
        o_hwrite <= i_rd0_wr1;
        o_htrans <= HTRANS_NONSEQ;
        wdata_q  <= i_wr_data;
      end else if (addr_done || enter_err) begin
        o_htrans <= HTRANS_IDLE;
      end else if (reissue) begin
        o_htrans <= HTRANS_NONSEQ;
      end
      if (addr_done) begin
        o_hwdata <= wdata_q;
        dp_wr_q  <= o_hwrite;
      end
      if (enter_err) b_held_q <= (state_q == S_PIPE);
    end
  end

  always_ff @(posedge i_clk_sink) begin
    if (!i_rstn_sink) begin
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_rd_valid <= data_done && !dp_wr_q;
      o_err      <= data_done && data_err;
      if (data_done && !dp_wr_q)
        o_rd_data <= data_err ? ERR_PATTERN : i_hrdata;
    end
  end

endmodule

// File: tb/tb_ahb_sink_master.sv
// Directed and random stimulus for ahb_sink_master
// against a transaction-level AHB slave model.
module tb_ahb_sink_master;
  import ahb_bridge_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int waits;
    bit err;
    bit single;
  } plan_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic        rd0_wr1;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        hold;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  always #5 clk = ~clk;

  ahb_sink_master dut (
    .i_clk_sink  (clk),
    .i_rstn_sink (rstn),
    .i_valid     (valid),
    .i_rd0_wr1   (rd0_wr1),
    .i_addr      (addr),
    .i_wr_data   (wr_data),
    .o_ready     (ready),
    .i_hold      (hold),
    .o_busy      (busy),
    .o_rd_valid  (rd_valid),
    .o_rd_data   (rd_data),
    .o_err       (err),
    .o_haddr     (haddr),
    .o_htrans    (htrans),
    .o_hwrite    (hwrite),
    .o_hsize     (hsize),
    .o_hburst    (hburst),
    .o_hwdata    (hwdata),
    .i_hrdata    (hrdata),
    .i_hready    (hready),
    .i_hresp     (hresp)
  );

  req_t  req_q[$];
  req_t  iss_q[$];
  plan_t plan_q[$];
  logic [31:0] mem [logic [31:0]];

  bit          dp_v, dp_wr, dp_err, dp_single, dp_step;
  int          dp_waits;
  logic [31:0] dp_addr, dp_data;
  bit          exp_rv, exp_er;
  logic [31:0] exp_rd;
  int          outstanding;
  bit          prev_stall, prev_err1;
  logic [31:0] prev_addr;
  logic        prev_wr;
  bit          rnd_on, rst_req, force_hold, rst_seen;
  int          cyc, n_chk, n_err;
  int          nonseq_cyc, rv_cnt, er_cnt, nrdy_cnt, aph_cnt;
  int          last_rd_acc, last_rdv;

  task automatic chk(string tag, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic model_reset();
    iss_q.delete();
    req_q.delete();
    plan_q.delete();
    dp_v        = 0;
    outstanding = 0;
    exp_rv      = 0;
    exp_er      = 0;
    prev_stall  = 0;
    prev_err1   = 0;
  endtask

  task automatic step();
    bit    h, e, acc;
    req_t  r;
    plan_t p;
    @(negedge clk);
    cyc++;
    if (rst_seen) begin
      chk("rd_valid", rd_valid, exp_rv);
      chk("err", err, exp_er);
      if (exp_rv) chk("rd_data", rd_data, exp_rd);
      chk("busy", busy, outstanding != 0);
      chk("htrans_legal", htrans == HTRANS_IDLE ||
          htrans == HTRANS_NONSEQ, 1);
      if (prev_stall) begin
        chk("haddr_hold", haddr, prev_addr);
        chk("htrans_hold", htrans, HTRANS_NONSEQ);
        chk("hwrite_hold", hwrite, prev_wr);
      end
      if (prev_err1) chk("htrans_err2", htrans, HTRANS_IDLE);
      if (rd_valid) begin
        rv_cnt++;
        last_rdv = cyc;
      end
      if (err) er_cnt++;
      if (htrans == HTRANS_NONSEQ) nonseq_cyc++;
    end
    h = 1;
    e = 0;
    if (dp_v) begin
      if (dp_waits > 0) h = 0;
      else if (dp_err && !dp_single && !dp_step) begin
        h = 0;
        e = 1;
      end else e = dp_err;
    end
    hready = h;
    hresp  = e ? HRESP_ERROR : HRESP_OKAY;
    hrdata = (dp_v && !dp_wr) ? memval(dp_addr) : $urandom;
    if (rnd_on && req_q.size() < 2) begin
      r.wr   = 1'($urandom_range(0, 1));
      r.addr = 32'h8000 + 32'($urandom_range(0, 15) * 4);
      r.data = $urandom;
      req_q.push_back(r);
    end
    hold  = rnd_on ? ($urandom_range(0, 9) == 0) : force_hold;
    valid = req_q.size() > 0 &&
            (!rnd_on || $urandom_range(0, 9) < 7);
    if (req_q.size() > 0) begin
      rd0_wr1 = req_q[0].wr;
      addr    = req_q[0].addr;
      wr_data = req_q[0].data;
    end else begin
      rd0_wr1 = 1'($urandom_range(0, 1));
      addr    = $urandom;
      wr_data = $urandom;
    end
    rstn = !rst_req;
    #1;
    if (hold || e || !rstn) chk("ready_block", ready, 0);
    if (rst_seen && htrans == HTRANS_NONSEQ && !h)
      chk("ready_stall", ready, 0);
    if (!rstn) begin
      model_reset();
      rst_seen = 1;
      return;
    end
    acc = valid && ready;
    if (valid && !ready) nrdy_cnt++;
    exp_rv = 0;
    exp_er = 0;
    if (dp_v && h) begin
      if (dp_wr) chk("hwdata", hwdata, dp_data);
      if (dp_wr && !dp_err) mem[dp_addr] = dp_data;
      exp_rv = !dp_wr;
      exp_er = dp_err;
      exp_rd = dp_err ? ERR_PATTERN_DEF : memval(dp_addr);
      dp_v   = 0;
      outstanding--;
    end else if (dp_v) begin
      if (dp_waits > 0) dp_waits--;
      else dp_step = 1;
    end
    prev_stall = (htrans == HTRANS_NONSEQ) && !h && !e;
    prev_err1  = !h && e;
    prev_addr  = haddr;
    prev_wr    = hwrite;
    if (htrans == HTRANS_NONSEQ && h) begin
      aph_cnt++;
      chk("aphase_pending", iss_q.size() != 0, 1);
      if (iss_q.size() != 0) begin
        r = iss_q.pop_front();
        chk("haddr", haddr, r.addr);
        chk("hwrite", hwrite, r.wr);
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else if (rnd_on) begin
          p.waits  = ($urandom_range(0, 3) == 0) ?
                     $urandom_range(1, 3) : 0;
          p.err    = ($urandom_range(0, 7) == 0);
          p.single = p.err && ($urandom_range(0, 3) == 0);
        end else begin
          p.waits  = 0;
          p.err    = 0;
          p.single = 0;
        end
        dp_v      = 1;
        dp_wr     = r.wr;
        dp_addr   = r.addr;
        dp_data   = r.data;
        dp_step   = 0;
        dp_waits  = p.waits;
        dp_err    = p.err;
        dp_single = p.single;
      end
    end
    if (acc) begin
      r = req_q.pop_front();
      iss_q.push_back(r);
      outstanding++;
      if (!r.wr) last_rd_acc = cyc;
    end
  endtask

  task automatic push(bit wr, logic [31:0] a, logic [31:0] d);
    req_t r;
    r.wr   = wr;
    r.addr = a;
    r.data = d;
    req_q.push_back(r);
  endtask

  task automatic plan(int w, bit er, bit s);
    plan_t p;
    p.waits  = w;
    p.err    = er;
    p.single = s;
    plan_q.push_back(p);
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((req_q.size() > 0 || outstanding > 0) && n < lim) begin
      step();
      n++;
    end
    step();
    step();
    chk("drain", req_q.size() + outstanding, 0);
  endtask

  task automatic clr_cnt();
    nonseq_cyc = 0;
    rv_cnt     = 0;
    er_cnt     = 0;
    nrdy_cnt   = 0;
    aph_cnt    = 0;
  endtask

  task automatic chk_idle_out(string t);
    chk({t, "_htrans"}, htrans, HTRANS_IDLE);
    chk({t, "_haddr"}, haddr, 0);
    chk({t, "_hwrite"}, hwrite, 0);
    chk({t, "_hwdata"}, hwdata, 0);
    chk({t, "_rd_valid"}, rd_valid, 0);
    chk({t, "_rd_data"}, rd_data, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_hsize"}, hsize, HSIZE_WORD);
    chk({t, "_hburst"}, hburst, HBURST_SINGLE);
  endtask

  initial begin
    int n;
    rstn = 0; valid = 0; rd0_wr1 = 0; addr = 0;
    wr_data = 0; hold = 0; hrdata = 0;
    hready = 1; hresp = 0;
    n_chk = 0; n_err = 0; cyc = 0;
    rnd_on = 0; force_hold = 0; rst_seen = 0;
    last_rd_acc = 0; last_rdv = 0;
    model_reset();
    clr_cnt();
    rst_req = 1;
    step();
    step();
    rst_req = 0;
    step();
    chk_idle_out("rst");

    clr_cnt();
    mem[32'h1000] = 32'hA5A5_0001;
    push(0, 32'h1000, 0);
    drain(20);
    chk("t1_lat", last_rdv - last_rd_acc, 3);
    chk("t1_nonseq", nonseq_cyc, 1);
    chk("t1_rv", rv_cnt, 1);

    clr_cnt();
    push(1, 32'h2000, 32'h1234_5678);
    push(0, 32'h2004, 0);
    drain(20);
    chk("t2_nrdy", nrdy_cnt, 0);
    chk("t2_aph", aph_cnt, 2);
    chk("t2_lat", last_rdv - last_rd_acc, 3);

    clr_cnt();
    push(0, 32'h2004, 0);
    push(1, 32'h2008, 32'hCAFE_0003);
    push(0, 32'h200C, 0);
    plan(2, 0, 0);
    plan(0, 0, 0);
    drain(30);
    chk("t3_nrdy", nrdy_cnt, 2);
    chk("t3_rv", rv_cnt, 2);

    clr_cnt();
    push(1, 32'h3000, 32'h0BAD_0004);
    push(0, 32'h3004, 0);
    plan(0, 1, 0);
    plan(0, 0, 0);
    drain(30);
    chk("t4_err", er_cnt, 1);
    chk("t4_rv", rv_cnt, 1);
    chk("t4_aph", aph_cnt, 2);
    chk("t4_nonseq", nonseq_cyc, 3);

    clr_cnt();
    push(0, 32'h4000, 0);
    push(0, 32'h4004, 0);
    plan(0, 1, 0);
    plan(0, 1, 1);
    drain(30);
    chk("t5_err", er_cnt, 2);
    chk("t5_rv", rv_cnt, 2);

    clr_cnt();
    push(0, 32'h5000, 0);
    push(0, 32'h5004, 0);
    push(0, 32'h5008, 0);
    n = 0;
    while (outstanding < 2 && n < 10) begin
      step();
      n++;
    end
    chk("t6_pipe", outstanding, 2);
    rst_req    = 1;
    force_hold = 1;
    step();
    rst_req = 0;
    step();
    chk_idle_out("t6");
    chk("t6_ready", ready, 0);
    step();
    chk("t6_busy2", busy, 0);
    chk("t6_ready2", ready, 0);
    force_hold = 0;

    clr_cnt();
    rnd_on = 1;
    repeat (2000) step();
    rnd_on = 0;
    drain(300);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
